// File: rtl/hm2reg_arbiter_pkg.sv
// Shared types and helpers for the hm2 register-port arbiter.
// The optional HM2REG_ARB_LOCK_EN feature does not change anything here.
package hm2reg_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int SUM_W   = IDX_W + 1;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [MAX_REQ-1:0] req_vec_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  // (a + b) mod n for a, b < n <= MAX_REQ.
  function automatic idx_t wrap_add(input idx_t a, input idx_t b, input int n);
    logic [SUM_W-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= SUM_W'(n)) s = s - SUM_W'(n);
    return s[IDX_W-1:0];
  endfunction

  // Round-robin pick: rotate so ptr lands at bit 0, take the lowest set bit,
  // then rotate the index back. Returns ptr when nothing is requested.
  function automatic idx_t rr_pick(input req_vec_t req, input idx_t ptr, input int num_req);
    req_vec_t rot;
    idx_t     first;
    logic     found;
    rot   = '0;
    first = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < num_req) rot[i] = req[wrap_add(ptr, idx_t'(i), num_req)];
    end
    for (int i = 0; i < MAX_REQ; i++) begin
      if (!found && rot[i]) begin
        first = idx_t'(i);
        found = 1'b1;
      end
    end
    return wrap_add(ptr, first, num_req);
  endfunction

endpackage

// File: rtl/hm2reg_arbiter_if.sv
// Requester + hm2 register-port bundle for hm2reg_arbiter.
// HM2REG_ARB_LOCK_EN adds the per-requester req_lock signal.
//
// Handshake: req[i] acts as valid and is held with stable req_write/addr/wdata
// until ack[i]; ack[i] is a one-cycle completion pulse (there is no separate
// ready). The arbiter only samples requests while idle, so a req dropped before
// its grant is never served, and a req still high the cycle after ack is
// treated as a new request.
interface hm2reg_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 32
);
  logic [NUM_REQ-1:0]               req;
  logic [NUM_REQ-1:0]               req_write;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata;
`ifdef HM2REG_ARB_LOCK_EN
  logic [NUM_REQ-1:0]               req_lock;
`endif
  logic [NUM_REQ-1:0]               ack;
  logic [DATA_WIDTH-1:0]            rdata;
  logic                             busy;
  logic [ADDRESS_WIDTH-1:0]         con_adrout;
  logic [DATA_WIDTH-1:0]            con_dataout;
  logic                             con_write_out;
  logic                             con_read_out;
  logic                             con_chip_sel;
  logic [DATA_WIDTH-1:0]            con_datain;

  // Arbiter view.
  modport slave (
`ifdef HM2REG_ARB_LOCK_EN
    input  req_lock,
`endif
    input  req, req_write, req_addr, req_wdata, con_datain,
    output ack, rdata, busy, con_adrout, con_dataout,
    output con_write_out, con_read_out, con_chip_sel
  );

  // Environment view: requesters plus the hm2 register file.
  modport master (
`ifdef HM2REG_ARB_LOCK_EN
    output req_lock,
`endif
    output req, req_write, req_addr, req_wdata, con_datain,
    input  ack, rdata, busy, con_adrout, con_dataout,
    input  con_write_out, con_read_out, con_chip_sel
  );

endinterface

// File: rtl/hm2reg_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate by ptr, priority-encode, unrotate.
// Not affected by HM2REG_ARB_LOCK_EN (masking is done by the caller).
module hm2reg_rr_pick
  import hm2reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  idx_t               ptr,
  output logic               valid,
  output idx_t               index
);

  req_vec_t req_ext;

  // Widen to the package vector width and pick the winner.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    valid                  = |req;
    index                  = rr_pick(req_ext, ptr, NUM_REQ);
  end

endmodule

// File: rtl/hm2reg_arbiter.sv
// Round-robin arbiter sharing the single HostMot2 register port among NUM_REQ
// requesters. One single-beat access at a time: IDLE -> ISSUE -> (WAIT_RD) -> DONE.
// Define HM2REG_ARB_LOCK_EN to add req_lock: a winner that finishes with its
// lock high keeps exclusive access (rr pointer frozen, others masked) until it
// completes a transaction with the lock low.
module hm2reg_arbiter
  import hm2reg_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              reset,
  hm2reg_arbiter_if.slave   bus,
  output arb_state_t        state_dbg
);

  localparam logic [2:0] RD_LAST = 3'(READ_LATENCY - 1);

  arb_state_t               state;
  idx_t                     rr_ptr;
  idx_t                     winner;
  logic                     is_write;
  logic [2:0]               rd_cnt;
  logic [ADDRESS_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0]    dout_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     wr_q;
  logic                     rd_q;
  logic                     cs_q;
  logic [NUM_REQ-1:0]       ack_q;

  logic [NUM_REQ-1:0]       req_elig;
  logic                     pick_valid;
  idx_t                     pick_idx;
  logic                     sel_write;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;
  logic [NUM_REQ-1:0]       winner_onehot;
`ifdef HM2REG_ARB_LOCK_EN
  logic                     lock_q;
  logic                     winner_lock;
`endif

  // Requests offered to the picker; an active lock leaves only its owner.
  always_comb begin
    req_elig = bus.req;
`ifdef HM2REG_ARB_LOCK_EN
    if (lock_q) req_elig = bus.req & winner_onehot;
`endif
  end

  hm2reg_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_elig),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // Select the picked requester's command and decode the current winner.
  always_comb begin
    sel_write     = 1'b0;
    sel_addr      = '0;
    sel_wdata     = '0;
    winner_onehot = '0;
`ifdef HM2REG_ARB_LOCK_EN
    winner_lock   = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == idx_t'(i)) begin
        sel_write = bus.req_write[i];
        sel_addr  = bus.req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (winner == idx_t'(i)) begin
        winner_onehot[i] = 1'b1;
`ifdef HM2REG_ARB_LOCK_EN
        winner_lock      = bus.req_lock[i];
`endif
      end
    end
  end

  // Transaction FSM with registered bus strobes, ack and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      winner   <= '0;
      is_write <= 1'b0;
      rd_cnt   <= '0;
      adr_q    <= '0;
      dout_q   <= '0;
      rdata_q  <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cs_q     <= 1'b0;
      ack_q    <= '0;
`ifdef HM2REG_ARB_LOCK_EN
      lock_q   <= 1'b0;
`endif
    end else begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      ack_q <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            winner   <= pick_idx;
            is_write <= sel_write;
            adr_q    <= sel_addr;
            dout_q   <= sel_wdata;
            cs_q     <= 1'b1;
            wr_q     <= sel_write;
            rd_q     <= !sel_write;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          rd_cnt <= '0;
          if (is_write) begin
            cs_q  <= 1'b0;
            ack_q <= winner_onehot;
            state <= DONE;
          end else begin
            state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (rd_cnt == RD_LAST) begin
            rdata_q <= bus.con_datain;
            cs_q    <= 1'b0;
            ack_q   <= winner_onehot;
            state   <= DONE;
          end else begin
            rd_cnt <= rd_cnt + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef HM2REG_ARB_LOCK_EN
          if (winner_lock) begin
            lock_q <= 1'b1;
          end else begin
            lock_q <= 1'b0;
            rr_ptr <= wrap_add(winner, idx_t'(1), NUM_REQ);
          end
`else
          rr_ptr <= wrap_add(winner, idx_t'(1), NUM_REQ);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack           = ack_q;
  assign bus.rdata         = rdata_q;
  assign bus.busy          = (state != IDLE);
  assign bus.con_adrout    = adr_q;
  assign bus.con_dataout   = dout_q;
  assign bus.con_write_out = wr_q;
  assign bus.con_read_out  = rd_q;
  assign bus.con_chip_sel  = cs_q;
  assign state_dbg         = state;

endmodule

// File: tb/tb_hm2reg_arbiter.sv
// Directed bench for hm2reg_arbiter (READ_LATENCY = 2). A transaction-level
// model predicts every output each cycle; directed scenarios add literal checks.
// The lock scenario runs only when HM2REG_ARB_LOCK_EN is defined.
module tb_hm2reg_arbiter;
  import hm2reg_arb_pkg::*;

  localparam int NR = 4;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int RL = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  hm2reg_arbiter_if #(.NUM_REQ(NR), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  arb_state_t state_dbg;

  hm2reg_arbiter #(.NUM_REQ(NR), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- hm2 register file model ----------------
  logic [DW-1:0]  mem [int];
  int             rd_valid_cyc = -1;
  int             rd_addr      = 0;
  int             wr_cnt       = 0;
  logic [AW-1:0]  wr_addr_seen = '0;
  logic [DW-1:0]  wr_data_seen = '0;

  function automatic logic [DW-1:0] mem_rd(input int a);
    if (mem.exists(a)) return mem[a];
    return 32'hA500_0000 | 32'(a);
  endfunction

  // Capture strobes; read data becomes valid RL cycles after the read strobe.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.con_write_out === 1'b1) begin
        mem[int'(bus.con_adrout)] = bus.con_dataout;
        wr_cnt++;
        wr_addr_seen = bus.con_adrout;
        wr_data_seen = bus.con_dataout;
      end
      if (bus.con_read_out === 1'b1) begin
        rd_valid_cyc = cyc + RL;
        rd_addr      = int'(bus.con_adrout);
      end
    end
  end

  // Outside the valid cycle the data bus carries a poison pattern.
  always @(posedge clk) begin
    #1;
    bus.con_datain = (cyc == rd_valid_cyc) ? mem_rd(rd_addr) : (32'hBAD0_0000 | (32'(cyc) & 32'hFFFF));
  end

  // ---------------- behavioural arbiter model ----------------
  bit            m_active = 1'b0;
  int            m_age = 0, m_len = 0, m_win = 0, m_ptr = 0;
  logic          m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0, m_rd_exp = '0;
  bit            m_lock = 1'b0;
  int            m_lock_owner = 0;
  logic [7:0]    exp_q[$];

  always @(posedge clk) begin
    logic [NR-1:0] elig;
    int            w;
    if (reset) begin
      m_active = 1'b0; m_age = 0; m_ptr = 0; m_lock = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      exp_q.delete();
    end else if (!m_active) begin
      elig = bus.req;
      if (m_lock) elig = elig & (NR'(1) << m_lock_owner);
      w = -1;
      for (int k = 0; k < NR; k++) begin
        if (w < 0 && elig[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      end
      if (w >= 0) begin
        m_active = 1'b1;
        m_age    = 1;
        m_win    = w;
        m_wr     = bus.req_write[w];
        m_addr   = bus.req_addr[w*AW +: AW];
        m_wdata  = bus.req_wdata[w*DW +: DW];
        m_len    = m_wr ? 2 : RL + 2;
        m_rd_exp = mem_rd(int'(m_addr));
        exp_q.push_back(8'(w));
      end
    end else if (m_age == m_len) begin
      m_active = 1'b0;
`ifdef HM2REG_ARB_LOCK_EN
      if (bus.req_lock[m_win]) begin
        m_lock = 1'b1;
        m_lock_owner = m_win;
      end else begin
        m_lock = 1'b0;
        m_ptr  = (m_win + 1) % NR;
      end
`else
      m_ptr = (m_win + 1) % NR;
`endif
    end else begin
      m_age++;
      if (m_age == m_len && !m_wr) m_rdata = m_rd_exp;
    end
  end

  // ---------------- compare process + scoreboard ----------------
  int ack_log[$];
  int ack_cnt[NR];

  always @(negedge clk) begin
    logic [NR-1:0] e_ack;
    logic [7:0]    w;
    if (cmp_en) begin
      e_ack = (m_active && m_age == m_len) ? (NR'(1) << m_win) : '0;
      check("busy",      bus.busy,          m_active);
      check("chip_sel",  bus.con_chip_sel,  m_active && m_age < m_len);
      check("write_out", bus.con_write_out, m_active && m_age == 1 && m_wr);
      check("read_out",  bus.con_read_out,  m_active && m_age == 1 && !m_wr);
      check("adrout",    bus.con_adrout,    m_addr);
      check("dataout",   bus.con_dataout,   m_wdata);
      check("ack",       bus.ack,           e_ack);
      check("rdata",     bus.rdata,         m_rdata);
      if (bus.ack !== '0) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_ack", bus.ack, '0);
        end else begin
          w = exp_q.pop_front();
          check("sb_ack_owner", bus.ack, NR'(1) << w);
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (bus.ack[i] === 1'b1) begin
        ack_log.push_back(i);
        ack_cnt[i]++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input bit w, input int a, input logic [DW-1:0] d);
    bus.req_write[i]         = w;
    bus.req_addr[i*AW +: AW] = AW'(a);
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  // Waits (bounded) for ack[i]; returns at the negedge of the ack cycle.
  task automatic wait_ack(input int i, output int ack_cycle, output logic [DW-1:0] rd);
    ack_cycle = -1;
    rd        = '0;
    for (int t = 0; t < 40 && ack_cycle < 0; t++) begin
      @(negedge clk);
      if (bus.ack[i] === 1'b1) begin
        ack_cycle = cyc;
        rd        = bus.rdata;
      end
    end
    if (ack_cycle < 0) check("ack_timeout", 64'(i), 64'hFF);
  endtask

  // One complete transaction; lat counts the request cycle as cycle 1.
  task automatic do_txn(input int i, input bit w, input int a, input logic [DW-1:0] d,
                        output int lat, output logic [DW-1:0] rd);
    int c0, ca;
    step();
    set_cmd(i, w, a, d);
    bus.req[i] = 1'b1;
    c0 = cyc;
    wait_ack(i, ca, rd);
    lat = (ca < 0) ? -1 : ca - c0 + 1;
    step();
    bus.req[i] = 1'b0;
  endtask

  function automatic int ack_at(input int k);
    if (k < ack_log.size()) return ack_log[k];
    return -1;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int            lat, base, ca, n3, w0;
    logic [DW-1:0] rd;
    int            fair_exp[5] = '{0, 1, 2, 3, 0};

    reset          = 1'b1;
    bus.req        = '0;
    bus.req_write  = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.con_datain = '0;
`ifdef HM2REG_ARB_LOCK_EN
    bus.req_lock   = '0;
`endif
    mem[32'h200] = 32'h1234_5678;

    // Reset state.
    step();
    cmp_en = 1'b1;
    step();
    @(negedge clk);
    check("rst_busy",     bus.busy, 1'b0);
    check("rst_ack",      bus.ack, '0);
    check("rst_chip_sel", bus.con_chip_sel, 1'b0);
    check("rst_rdata",    bus.rdata, '0);
    step();
    reset = 1'b0;

    // 1. Single write from requester 0.
    w0 = wr_cnt;
    do_txn(0, 1'b1, 32'h0100, 32'hDEAD_BEEF, lat, rd);
    check("wr_latency",     64'(lat), 64'd3);
    check("wr_strobe_cnt",  64'(wr_cnt - w0), 64'd1);
    check("wr_strobe_addr", wr_addr_seen, 14'h0100);
    check("wr_strobe_data", wr_data_seen, 32'hDEAD_BEEF);

    // 2. Read from requester 1.
    do_txn(1, 1'b0, 32'h0200, 32'h0, lat, rd);
    check("rd_latency", 64'(lat), 64'd5);
    check("rd_data",    rd, 32'h1234_5678);

    // A write leaves rdata untouched.
    do_txn(2, 1'b1, 32'h0210, 32'h0BAD_F00D, lat, rd);
    check("wr_latency_r2",  64'(lat), 64'd3);
    @(negedge clk);
    check("rdata_held",     bus.rdata, 32'h1234_5678);

    // 4. Reset while requester 3's read waits for data.
    n3 = ack_cnt[3];
    step();
    set_cmd(3, 1'b0, 32'h0300, 32'h0);
    bus.req[3] = 1'b1;
    step();
    step();
    reset      = 1'b1;
    bus.req[3] = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_chip_sel", bus.con_chip_sel, 1'b0);
    check("rst_mid_read_out", bus.con_read_out, 1'b0);
    check("rst_mid_adrout",   bus.con_adrout, '0);
    check("rst_mid_busy",     bus.busy, 1'b0);
    repeat (8) step();
    check("rst_mid_no_ack3",  64'(ack_cnt[3] - n3), 64'd0);

    // 3. Fairness with all four requesting continuously.
    step();
    for (int i = 0; i < NR; i++) set_cmd(i, 1'b1, 32'h0010 + i, 32'h100 + i);
    base = ack_log.size();
    bus.req = 4'b1111;
    for (int t = 0; t < 100 && ack_log.size() < base + 5; t++) begin
      @(negedge clk);
      #1;
    end
    step();
    bus.req = '0;
    check("post_reset_first_grant", 64'(ack_at(base)), 64'd0);
    for (int k = 1; k < 5; k++) check($sformatf("fair_order_%0d", k), 64'(ack_at(base + k)), 64'(fair_exp[k]));

    // 6. Requester 3 pulses for one cycle while requester 0 reads.
    n3 = ack_cnt[3];
    step();
    set_cmd(0, 1'b0, 32'h0400, 32'h0);
    bus.req[0] = 1'b1;
    step();
    step();
    set_cmd(3, 1'b1, 32'h0444, 32'h4444_4444);
    bus.req[3] = 1'b1;
    step();
    bus.req[3] = 1'b0;
    wait_ack(0, ca, rd);
    check("late_rd_data", rd, 32'hA500_0400);
    step();
    bus.req[0] = 1'b0;
    repeat (10) step();
    check("late_drop_no_ack", 64'(ack_cnt[3] - n3), 64'd0);

`ifdef HM2REG_ARB_LOCK_EN
    // 5. Locked read-modify-write by requester 2 while requester 0 waits.
    step();
    base = ack_log.size();
    set_cmd(2, 1'b0, 32'h0500, 32'h0);
    set_cmd(0, 1'b0, 32'h0600, 32'h0);
    bus.req_lock[2] = 1'b1;
    bus.req = 4'b0101;
    wait_ack(2, ca, rd);
    step();
    set_cmd(2, 1'b1, 32'h0500, 32'h5555_0001);
    bus.req_lock[2] = 1'b0;
    wait_ack(2, ca, rd);
    step();
    bus.req[2] = 1'b0;
    wait_ack(0, ca, rd);
    step();
    bus.req[0] = 1'b0;
    check("lock_first",  64'(ack_at(base)),     64'd2);
    check("lock_again",  64'(ack_at(base + 1)), 64'd2);
    check("lock_release",64'(ack_at(base + 2)), 64'd0);
    repeat (4) step();
`endif

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    err_cnt++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
